// File: rtl/sim_integrator.sv
// Fixed-point double integrator: periodic ticks turn summed channel accelerations
// into velocity, then position, clamped to hard stops and reported as step deltas.
module sim_integrator #(
  parameter int unsigned SIM_PERIOD = 500_000,
  parameter int unsigned N_CH       = 3,
  parameter int unsigned FIXED_BITS = 16,
  parameter int unsigned PRECISION  = 16,
  parameter int unsigned VEL_GUARD  = 24,
  parameter int unsigned POS_FRAC   = 47,
  parameter int unsigned DT         = SIM_PERIOD,
  parameter logic signed [FIXED_BITS-1:0] POS_MIN = {1'b1, {(FIXED_BITS-1){1'b0}}},
  parameter logic signed [FIXED_BITS-1:0] POS_MAX = {1'b0, {(FIXED_BITS-1){1'b1}}}
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic [N_CH*(FIXED_BITS+PRECISION)-1:0]    acc_in,
  input  logic [N_CH-1:0]                           ch_en,
  input  logic                                      freeze,
  input  logic                                      load_pos,
  input  logic [FIXED_BITS-1:0]                     load_value,
  output logic [FIXED_BITS-1:0]                     current_pos,
  output logic [FIXED_BITS-1:0]                     delta_steps,
  output logic                                      step_valid,
  output logic                                      at_min,
  output logic                                      at_max,
  output logic                                      busy,
  output logic                                      sync_sim_clock
);

  localparam int unsigned W       = FIXED_BITS + PRECISION;
  localparam int unsigned SUM_W   = W + $clog2(N_CH) + 1;
  localparam int unsigned VEL_W   = W + VEL_GUARD;
  localparam int unsigned POS_W   = FIXED_BITS + PRECISION + POS_FRAC;
  localparam int unsigned FRAC_W  = PRECISION + POS_FRAC;
  localparam int unsigned DT_W    = 33;
  localparam int unsigned VPROD_W = SUM_W + DT_W;
  localparam int unsigned VACC_W  = ((VEL_W > VPROD_W) ? VEL_W : VPROD_W) + 1;
  localparam int unsigned PPROD_W = VEL_W + DT_W;
  localparam int unsigned PACC_W  = ((POS_W > PPROD_W) ? POS_W : PPROD_W) + 1;
  localparam int unsigned CNT_W   = (SIM_PERIOD > 1) ? $clog2(SIM_PERIOD) : 1;
  localparam int unsigned D_W     = FIXED_BITS + 1;

  localparam logic [CNT_W-1:0]        TICK_CNT     = CNT_W'(SIM_PERIOD - 1);
  localparam logic [CNT_W-1:0]        HALF_CNT     = CNT_W'(SIM_PERIOD / 2);
  localparam logic signed [DT_W-1:0]  DT_S         = DT_W'(DT);
  localparam logic signed [POS_W-1:0] POS_MAX_FULL = POS_W'(POS_MAX) <<< FRAC_W;
  localparam logic signed [POS_W-1:0] POS_MIN_FULL = POS_W'(POS_MIN) <<< FRAC_W;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SUM  = 3'd1;
  localparam logic [2:0] VEL  = 3'd2;
  localparam logic [2:0] POS  = 3'd3;
  localparam logic [2:0] OUT  = 3'd4;

  logic [2:0]                   state, state_next;
  logic [CNT_W-1:0]             cnt, cnt_next_c;
  logic                         tick_c;
  logic signed [SUM_W-1:0]      acc_sum, acc_sum_c;
  logic signed [VEL_W-1:0]      vel, vel_sat_c;
  logic signed [VACC_W-1:0]     vel_acc_c;
  logic signed [POS_W-1:0]      pos, pos_sat_c, pos_new_c;
  logic signed [PACC_W-1:0]     pos_acc_c;
  logic signed [FIXED_BITS-1:0] pos_int_c, pos_out_c, delta_sat_c;
  logic signed [D_W-1:0]        delta_c;
  logic                         hit_max_c, hit_min_c;

  // Free-running step timebase, independent of freeze
  always_comb begin
    tick_c     = (cnt == TICK_CNT);
    cnt_next_c = tick_c ? '0 : cnt + CNT_W'(1);
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; a load always aborts back to IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tick_c && !freeze) state_next = SUM;
      SUM:     state_next = VEL;
      VEL:     state_next = POS;
      POS:     state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (load_pos) state_next = IDLE;
  end

  // Sum of enabled channels, wide enough that it never overflows
  always_comb begin
    acc_sum_c = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (ch_en[k]) acc_sum_c = acc_sum_c + SUM_W'($signed(acc_in[k*W +: W]));
    end
  end

  // Saturating velocity and position integrators
  always_comb begin
    vel_acc_c = VACC_W'(vel) + VACC_W'(acc_sum) * VACC_W'(DT_S);
    if (&vel_acc_c[VACC_W-1:VEL_W-1] || ~|vel_acc_c[VACC_W-1:VEL_W-1])
      vel_sat_c = vel_acc_c[VEL_W-1:0];
    else
      vel_sat_c = {vel_acc_c[VACC_W-1], {(VEL_W-1){~vel_acc_c[VACC_W-1]}}};

    pos_acc_c = PACC_W'(pos) + PACC_W'(vel) * PACC_W'(DT_S);
    if (&pos_acc_c[PACC_W-1:POS_W-1] || ~|pos_acc_c[PACC_W-1:POS_W-1])
      pos_sat_c = pos_acc_c[POS_W-1:0];
    else
      pos_sat_c = {pos_acc_c[PACC_W-1], {(POS_W-1){~pos_acc_c[PACC_W-1]}}};
    pos_int_c = pos_sat_c[POS_W-1 -: FIXED_BITS];
  end

  // Hard-stop clamp and saturated step delta
  always_comb begin
    pos_new_c = pos_sat_c;
    pos_out_c = pos_int_c;
    hit_max_c = 1'b0;
    hit_min_c = 1'b0;
    if (pos_int_c > POS_MAX) begin
      pos_new_c = POS_MAX_FULL;
      pos_out_c = POS_MAX;
      hit_max_c = 1'b1;
    end else if (pos_int_c < POS_MIN) begin
      pos_new_c = POS_MIN_FULL;
      pos_out_c = POS_MIN;
      hit_min_c = 1'b1;
    end
    delta_c = D_W'(pos_out_c) - D_W'($signed(current_pos));
    if (delta_c[D_W-1] != delta_c[D_W-2])
      delta_sat_c = {delta_c[D_W-1], {(FIXED_BITS-1){~delta_c[D_W-1]}}};
    else
      delta_sat_c = delta_c[FIXED_BITS-1:0];
  end

  // Datapath and registered outputs; clamp and output update share the POS edge
  // so that step_valid is high exactly during the OUT cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt            <= '0;
      acc_sum        <= '0;
      vel            <= '0;
      pos            <= '0;
      current_pos    <= '0;
      delta_steps    <= '0;
      step_valid     <= 1'b0;
      at_min         <= 1'b0;
      at_max         <= 1'b0;
      busy           <= 1'b0;
      sync_sim_clock <= 1'b0;
    end else begin
      cnt            <= cnt_next_c;
      sync_sim_clock <= (cnt_next_c < HALF_CNT);
      busy           <= (state_next != IDLE);
      step_valid     <= 1'b0;
      if (load_pos) begin
        pos         <= POS_W'($signed(load_value)) <<< FRAC_W;
        vel         <= '0;
        current_pos <= load_value;
        delta_steps <= '0;
        at_min      <= 1'b0;
        at_max      <= 1'b0;
      end else begin
        case (state)
          SUM: acc_sum <= acc_sum_c;
          VEL: vel     <= vel_sat_c;
          POS: begin
            pos         <= pos_new_c;
            vel         <= (hit_max_c || hit_min_c) ? '0 : vel;
            current_pos <= pos_out_c;
            delta_steps <= delta_sat_c;
            at_max      <= hit_max_c;
            at_min      <= hit_min_c;
            step_valid  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/sim_integrator.md
SIM_INTEGRATOR -- requirements
Module: sim_integrator

Interface
REQ-001 SHALL have parameters (name, default, meaning): SIM_PERIOD, 500_000, clock cycles per simulation step (>= 8).
REQ-002 SHALL have parameter N_CH, 3, number of acceleration channels.
REQ-003 SHALL have parameter FIXED_BITS, 16, integer width of position outputs (step/16 units).
REQ-004 SHALL have parameter PRECISION, 16, fractional bits of acceleration inputs.
REQ-005 SHALL have parameters VEL_GUARD, 24, velocity accumulator extra MSBs; POS_FRAC, 47, position accumulator extra fractional bits; DT, SIM_PERIOD, integration multiplier.
REQ-006 SHALL have parameters POS_MIN and POS_MAX (FIXED_BITS signed), defaults most-negative and most-positive, hard stops.
REQ-007 SHALL have ports: clock in 1 system clock; reset in 1 synchronous active-low reset.
REQ-008 SHALL have acc_in in N_CH*W signed accelerations (W=FIXED_BITS+PRECISION, channel k at bits [k*W +: W]); ch_en in N_CH channel enable mask.
REQ-009 SHALL have freeze in 1 (ignore ticks); load_pos in 1 strobe; load_value in FIXED_BITS signed.
REQ-010 SHALL have outputs current_pos out FIXED_BITS signed; delta_steps out FIXED_BITS signed; step_valid out 1; at_min out 1; at_max out 1; busy out 1; sync_sim_clock out 1.

Function
REQ-011 SHALL run tick counter 0..SIM_PERIOD-1 wrapping; tick = counter==SIM_PERIOD-1; sync_sim_clock SHALL be 1 while counter < SIM_PERIOD/2. Counter runs regardless of freeze.
REQ-012 SHALL use single clock domain; no derived clocks.
REQ-013 FSM states IDLE, SUM, VEL, POS, OUT; IDLE->SUM on tick with freeze=0; SUM->VEL->POS->OUT->IDLE one cycle each; busy=1 in non-IDLE states.
REQ-014 SUM: acc_sum = sum of enabled channels, sign-extended to W+clog2(N_CH)+1 bits, no overflow possible.
REQ-015 VEL: vel <= sat_VEL_W(vel + acc_sum*DT), VEL_W=W+VEL_GUARD, saturating to signed bounds, never wrapping.
REQ-016 POS: pos <= sat_POS_W(pos + vel*DT), POS_W=FIXED_BITS+PRECISION+POS_FRAC; pos_int = pos[POS_W-1 -: FIXED_BITS].
REQ-017 OUT: if pos_int > POS_MAX, pos <= POS_MAX at integer field with zeroed fraction, vel <= 0, at_max <= 1; symmetric for POS_MIN/at_min; else both flags 0.
REQ-018 OUT: delta_steps <= clamped new position - previous current_pos, computed FIXED_BITS+1 wide, saturated to FIXED_BITS; current_pos <= clamped new position; step_valid pulses 1 for exactly that cycle.
REQ-019 Latency: outputs update 4 cycles after the tick cycle (tick at t, step_valid at t+4).
REQ-020 load_pos (any state) SHALL override: next cycle pos integer field <= load_value, fraction 0, vel <= 0, current_pos <= load_value, delta_steps <= 0, at_min/at_max <= 0, FSM -> IDLE, step_valid 0; in-flight step discarded.
REQ-021 load_pos coincident with tick SHALL load only; that tick is dropped.
REQ-022 freeze=1 at tick SHALL drop that tick; a step already in progress completes.
REQ-023 ch_en/acc_in SHALL be sampled only in SUM.

Reset
REQ-024 reset=0 at a clock edge SHALL clear counter, vel, pos, current_pos, delta_steps, step_valid, at_min, at_max, busy, sync_sim_clock to 0 and FSM to IDLE, including mid-step.
REQ-025 Reset SHALL take priority over load_pos and tick.

Verification (bench params SIM_PERIOD=8, N_CH=3, PRECISION=0, POS_FRAC=0, VEL_GUARD=8, DT=1)
REQ-026 acc ch0=1, others 0, all enabled, 3 ticks -> current_pos 1,3,6; delta_steps 1,2,3; step_valid 4 cycles after each tick.
REQ-027 ch0=5, ch1=-5, ch2=2, ch_en=3'b011 -> every step delta_steps=0, current_pos=0.
REQ-028 POS_MAX=10, ch0=4 -> positions 4,12->clamped 10 with at_max=1, delta 6; next step vel=0 so +4 -> 10 again, at_max=1.
REQ-029 load_pos=1, load_value=-7 asserted in VEL state -> next cycle current_pos=-7, delta_steps=0, busy=0, no step_valid for that tick.
REQ-030 freeze=1 over 2 ticks -> no step_valid, outputs held, sync_sim_clock keeps toggling period 8.
REQ-031 reset=0 during POS state -> next cycle all outputs 0, FSM IDLE; first step after release from acc 1 yields current_pos 1.
